// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// Synchronous FIFO controller in front of a single-port 8x8 byte RAM.
// After reset it zero-fills every RAM location (busy=1), then runs the RAM
// as a circular buffer, arbitrating producer writes and consumer reads onto
// the one RAM port, at most one access per cycle.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   clr                 flush: pointers and count cleared, RAM untouched
//   wr_en, wr_data      producer request and byte; wr_ack when accepted
//   rd_en               consumer request; rd_ack when accepted
//   rd_data, rd_valid   registered read byte and its one-cycle strobe
//   full, empty, count  occupancy status (count is 0..DEPTH)
//   busy                high while the RAM is being zero-filled
//   ram_addr, ram_d_in, ram_cs, ram_rw (1 = write), ram_d_out  RAM port
module ram_fifo_ctrl #(
   parameter int AW    = 3,
   parameter int DW    = 8,
   parameter int DEPTH = 8    // must equal 2**AW so pointers wrap naturally
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ack,
   input  logic          rd_en,
   output logic          rd_ack,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          busy,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_d_in,
   output logic          ram_cs,
   output logic          ram_rw,
   input  logic [DW-1:0] ram_d_out
);

   localparam logic [AW:0]   COUNT_MAX = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t        state, state_next;
   logic [AW-1:0] init_addr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          prio;
   logic          run;
   logic          wr_ok;
   logic          rd_ok;
   logic          contested;
   logic          do_wr;
   logic          do_rd;

   assign full  = (count == COUNT_MAX);
   assign empty = (count == '0);
   assign busy  = (state == ST_INIT);

   // A flush cycle grants nothing. When both sides are eligible, prio picks
   // the winner (0 = read); a lone eligible request always wins.
   assign run       = (state == ST_RUN) && !clr;
   assign wr_ok     = wr_en && !full;
   assign rd_ok     = rd_en && !empty;
   assign contested = wr_ok && rd_ok;
   assign do_wr     = run && wr_ok && (!rd_ok || prio);
   assign do_rd     = run && rd_ok && (!wr_ok || !prio);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_INIT;
      else     state <= state_next;
   end

   // Zero-fill ends after the cycle that writes the last address
   always_comb begin
      state_next = state;
      if (state == ST_INIT && init_addr == LAST_ADDR) state_next = ST_RUN;
   end

   // RAM port and acknowledges; the RAM is idle with all-zero outputs
   // whenever nothing is granted
   always_comb begin
      wr_ack   = 1'b0;
      rd_ack   = 1'b0;
      ram_cs   = 1'b0;
      ram_rw   = 1'b0;
      ram_addr = '0;
      ram_d_in = '0;
      if (state == ST_INIT) begin
         ram_cs   = 1'b1;
         ram_rw   = 1'b1;
         ram_addr = init_addr;
      end else if (do_wr) begin
         wr_ack   = 1'b1;
         ram_cs   = 1'b1;
         ram_rw   = 1'b1;
         ram_addr = wr_ptr;
         ram_d_in = wr_data;
      end else if (do_rd) begin
         rd_ack   = 1'b1;
         ram_cs   = 1'b1;
         ram_addr = rd_ptr;
      end
   end

   // Pointers, occupancy, read capture and arbitration priority. The RAM
   // read is combinational, so the byte is captured at the end of the
   // granted cycle and presented with rd_valid one cycle after rd_ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         init_addr <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         prio      <= 1'b0;
      end else if (state == ST_INIT) begin
         init_addr <= init_addr + AW'(1);
         rd_valid  <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= do_rd;
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + (AW+1)'(1);
         end
         if (do_rd) begin
            rd_ptr  <= rd_ptr + AW'(1);
            count   <= count - (AW+1)'(1);
            rd_data <= ram_d_out;
         end
         if (contested) prio <= !prio;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl with a behavioural 8x8 RAM attached.
// Directed stimulus; expected read bytes go into a scoreboard queue that a
// separate monitor pops whenever rd_valid is seen.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       wr_ack;
   logic       rd_en;
   logic       rd_ack;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       busy;
   logic [2:0] ram_addr;
   logic [7:0] ram_d_in;
   logic       ram_cs;
   logic       ram_rw;
   logic [7:0] ram_d_out;

   logic [7:0] mem [8];
   logic [7:0] exp_q [$];
   int         n_checks = 0;
   int         n_pass   = 0;

   always #5 clk = ~clk;

   ram_fifo_ctrl #(.AW(3), .DW(8), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .wr_en(wr_en), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_en(rd_en), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
      .full(full), .empty(empty), .count(count), .busy(busy),
      .ram_addr(ram_addr), .ram_d_in(ram_d_in), .ram_cs(ram_cs),
      .ram_rw(ram_rw), .ram_d_out(ram_d_out)
   );

   // Behavioural single-port RAM: synchronous write, combinational read
   always @(posedge clk) begin
      if (ram_cs && ram_rw) mem[ram_addr] <= ram_d_in;
   end
   assign ram_d_out = mem[ram_addr];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
   endtask

   // Scoreboard monitor: every rd_valid must match the oldest expected byte
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) checkOutput("rd_valid_unexpected", 32'(rd_valid), 32'd0);
         else checkOutput("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
   end

   // One clock cycle: drive just after the rising edge, return at the
   // falling edge so combinational outputs can be checked
   task automatic applyStimulus(input logic we, input logic [7:0] wd,
                                input logic re, input logic cl);
      @(posedge clk);
      #1;
      rst = 1'b0; wr_en = we; wr_data = wd; rd_en = re; clr = cl;
      @(negedge clk);
   endtask

   task automatic doReset();
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; wr_data = 8'h00;
      @(posedge clk);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd1);
      checkOutput("reset_empty_full", 32'({empty, full}), 32'b10);
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_rd_valid_data", 32'({rd_valid, rd_data}), 32'h000);
   endtask

   // Eight zero-fill cycles with every request asserted, all ignored
   task automatic runInit();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
         checkOutput("init_busy", 32'(busy), 32'd1);
         checkOutput("init_addr", 32'(ram_addr), 32'(i));
         checkOutput("init_ram_cs_rw_din", 32'({ram_cs, ram_rw, ram_d_in}), 32'h300);
         checkOutput("init_acks", 32'({wr_ack, rd_ack}), 32'd0);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("init_done_busy", 32'(busy), 32'd0);
      checkOutput("init_done_empty", 32'(empty), 32'd1);
      checkOutput("init_done_count", 32'(count), 32'd0);
   endtask

   task automatic writeByte(input logic [7:0] d, input int addr, input int cnt);
      applyStimulus(1'b1, d, 1'b0, 1'b0);
      checkOutput("wr_count", 32'(count), 32'(cnt));
      checkOutput("wr_ack", 32'(wr_ack), 32'd1);
      checkOutput("wr_ram", 32'({ram_cs, ram_rw, ram_addr, ram_d_in}), 32'({2'b11, 3'(addr), d}));
   endtask

   task automatic readByte(input logic [7:0] d, input int addr, input int cnt);
      exp_q.push_back(d);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("rd_count", 32'(count), 32'(cnt));
      checkOutput("rd_ack", 32'({wr_ack, rd_ack}), 32'b01);
      checkOutput("rd_ram", 32'({ram_cs, ram_rw, ram_addr}), 32'({2'b10, 3'(addr)}));
   endtask

   // Both requests held; grant_w selects which acknowledge is expected
   task automatic contest(input logic [7:0] wd, input logic grant_w,
                          input int addr, input int cnt);
      applyStimulus(1'b1, wd, 1'b1, 1'b0);
      checkOutput("contest_count", 32'(count), 32'(cnt));
      checkOutput("contest_acks", 32'({wr_ack, rd_ack}), 32'({grant_w, !grant_w}));
      checkOutput("contest_addr", 32'(ram_addr), 32'(addr));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'hEE;
      doReset();
      runInit();

      // Fill to full, then a refused ninth write
      for (int i = 0; i < 8; i++) writeByte(8'((i + 1) * 17), i, i);
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
      checkOutput("full_wr_ack", 32'(wr_ack), 32'd0);
      checkOutput("full_ram_cs", 32'(ram_cs), 32'd0);
      checkOutput("full_count", 32'(count), 32'd8);
      checkOutput("full_flag", 32'(full), 32'd1);

      // Drain, then a refused extra read
      for (int i = 0; i < 8; i++) readByte(8'((i + 1) * 17), i, 8 - i);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("empty_rd_ack", 32'(rd_ack), 32'd0);
      checkOutput("empty_ram_cs", 32'(ram_cs), 32'd0);
      checkOutput("empty_flag", 32'(empty), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("empty_rd_valid", 32'(rd_valid), 32'd0);

      // Wrap-around: advance both pointers to 5, then cross the top
      for (int i = 0; i < 5; i++) writeByte(8'(i + 1), i, i);
      for (int i = 0; i < 5; i++) readByte(8'(i + 1), i, 5 - i);
      for (int i = 0; i < 6; i++) writeByte(8'(8'hA0 + i), (5 + i) % 8, i);
      for (int i = 0; i < 6; i++) readByte(8'(8'hA0 + i), (5 + i) % 8, 6 - i);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("wrap_count", 32'(count), 32'd0);

      // Contention from count=3 (pointers at 3): R, W, R, W
      for (int i = 0; i < 3; i++) writeByte(8'(8'hC0 + i), 3 + i, i);
      exp_q.push_back(8'hC0);
      contest(8'hD0, 1'b0, 3, 3);
      contest(8'hD0, 1'b1, 6, 2);
      exp_q.push_back(8'hC1);
      contest(8'hD1, 1'b0, 4, 3);
      contest(8'hD1, 1'b1, 7, 2);
      readByte(8'hC2, 5, 3);
      readByte(8'hD0, 6, 2);
      readByte(8'hD1, 7, 1);
      // Empty: write wins uncontested, so the next contest still favours read
      contest(8'hE0, 1'b1, 0, 0);
      exp_q.push_back(8'hE0);
      contest(8'hE1, 1'b0, 0, 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("contest_end_count", 32'(count), 32'd0);

      // Flush with four entries stored (pointers at 1)
      for (int i = 0; i < 4; i++) writeByte(8'(8'hF0 + i), 1 + i, i);
      applyStimulus(1'b1, 8'hF4, 1'b1, 1'b1);
      checkOutput("clr_count_before", 32'(count), 32'd4);
      checkOutput("clr_acks", 32'({wr_ack, rd_ack}), 32'd0);
      checkOutput("clr_ram_cs", 32'(ram_cs), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("clr_count", 32'(count), 32'd0);
      checkOutput("clr_empty", 32'(empty), 32'd1);
      checkOutput("clr_rd_valid", 32'(rd_valid), 32'd0);
      writeByte(8'h5A, 0, 0);
      readByte(8'h5A, 0, 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      // Reset mid-stream with four entries stored
      for (int i = 0; i < 4; i++) writeByte(8'(8'h30 + i), 1 + i, i);
      doReset();
      runInit();
      writeByte(8'h77, 0, 0);
      readByte(8'h77, 0, 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
